gcn_argmax_collector: RTL and testbench



---
 rtl/gcn_argmax_collector.sv | 128 ++++++++++++
 tb/tb_gcn_argmax_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_argmax_collector.sv
// Row collector and argmax scanner behind the adjacency x (FM*WM) multiplier.
// Buffers one dot_product row per node, then emits the argmax column of each row.
module gcn_argmax_row #(
  parameter int W  = 3,
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [W-1:0][DW-1:0] din,
  output logic [W-1:0][DW-1:0] dout
);
  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk)
    if (we) dout <= din;
endmodule

module gcn_argmax_collector #(
  parameter int NUM_OF_NODES   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS),
  parameter int FEATURE_WIDTH  = $clog2(NUM_OF_NODES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [FEATURE_WIDTH-1:0]  write_row,
  input  logic [DOT_PROD_WIDTH-1:0] dot_product [0:WEIGHT_COLS-1],
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rows_full,
  output logic [WEIGHT_WIDTH-1:0]   max_addi_answer [0:NUM_OF_NODES-1]
);
  localparam logic [FEATURE_WIDTH-1:0] LAST_N  = FEATURE_WIDTH'(NUM_OF_NODES-1);
  localparam logic [WEIGHT_WIDTH-1:0]  LAST_C  = WEIGHT_WIDTH'(WEIGHT_COLS-1);
  localparam logic [FEATURE_WIDTH:0]   NODES_W = (FEATURE_WIDTH+1)'(NUM_OF_NODES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                                              state;
  logic [NUM_OF_NODES-1:0]                             row_written;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]          dp_pk;
  logic [NUM_OF_NODES-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_buf;
  logic [FEATURE_WIDTH-1:0]                            scan_n;
  logic [WEIGHT_WIDTH-1:0]                             scan_c;
  logic [DOT_PROD_WIDTH-1:0]                           best;
  logic [WEIGHT_WIDTH-1:0]                             idx;
  logic                                                cap_en;
  logic [DOT_PROD_WIDTH-1:0]                           elem;
  logic                                                first_c;
  logic                                                gt;
  logic [WEIGHT_WIDTH-1:0]                             idx_nxt;

  // The buffer only moves while idle; a scan always sees a frozen matrix.
  assign cap_en = (state == IDLE) && enable && ({1'b0, write_row} < NODES_W);

  for (genvar w = 0; w < WEIGHT_COLS; w++) begin : g_pack
    assign dp_pk[w] = dot_product[w];
  end

  for (genvar r = 0; r < NUM_OF_NODES; r++) begin : g_row
    gcn_argmax_row #(.W(WEIGHT_COLS), .DW(DOT_PROD_WIDTH)) u_row (
      .clk  (clk),
      .we   (cap_en && (write_row == FEATURE_WIDTH'(r))),
      .din  (dp_pk),
      .dout (row_buf[r])
    );
  end

  assign rows_full = &row_written;

  // Strict compare keeps the lower column on ties; idx_nxt folds in the current element.
  assign elem    = row_buf[scan_n][scan_c];
  assign first_c = (scan_c == '0);
  assign gt      = elem > best;
  assign idx_nxt = first_c ? '0 : (gt ? scan_c : idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      row_written <= '0;
      scan_n      <= '0;
      scan_c      <= '0;
      best        <= '0;
      idx         <= '0;
      for (int i = 0; i < NUM_OF_NODES; i++) max_addi_answer[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cap_en) row_written[write_row] <= 1'b1;
          if (start && rows_full) begin
            state  <= SCAN;
            busy   <= 1'b1;
            scan_n <= '0;
            scan_c <= '0;
          end
        end
        SCAN: begin
          if (first_c || gt) begin
            best <= elem;
            idx  <= idx_nxt;
          end
          if (scan_c == LAST_C) begin
            max_addi_answer[scan_n] <= idx_nxt;
            scan_c <= '0;
            scan_n <= scan_n + 1'b1;
            if (scan_n == LAST_N) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            scan_c <= scan_c + 1'b1;
          end
        end
        DONE: begin
          done        <= 1'b0;
          row_written <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcn_argmax_collector.sv
// Randomized scoreboard bench for gcn_argmax_collector against an argmax-per-row model.
module tb_gcn_argmax_collector;
  localparam int N  = 6;
  localparam int W  = 3;
  localparam int DW = 16;

  typedef logic [DW-1:0] dp_t [0:W-1];
  typedef struct {
    bit [N-1:0][1:0] ans;
    longint          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    write_row = '0;
  logic [DW-1:0] dot_product [0:W-1];
  logic          busy, done, rows_full;
  logic [1:0]    ans [0:N-1];

  gcn_argmax_collector dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .write_row       (write_row),
    .dot_product     (dot_product),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .rows_full       (rows_full),
    .max_addi_answer (ans)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] m_buf [0:N-1][0:W-1];
  bit [N-1:0]    m_mask = '0;
  longint        scan_k = -1000;
  longint        busy_until = -1;
  bit            mon_on = 1'b0;
  exp_t          q[$];
  dp_t           zero_row;
  dp_t           tbl [0:N-1];

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic dp_t mkrow(input int a, input int b, input int c);
    dp_t r;
    r[0] = a[DW-1:0]; r[1] = b[DW-1:0]; r[2] = c[DW-1:0];
    return r;
  endfunction

  function automatic dp_t rnd_row();
    dp_t r;
    for (int i = 0; i < W; i++)
      r[i] = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
    return r;
  endfunction

  // Drives the inputs for the next edge and advances the model for that edge.
  task automatic step(input bit en, input int row, input dp_t v, input bit st);
    longint e;
    bit     pre_full, blocked;
    exp_t   x;
    int     bi;
    @(negedge clk); #1;
    reset = 1'b0; enable = en; write_row = row[2:0]; dot_product = v; start = st;
    e        = cyc + 1;
    pre_full = &m_mask;
    blocked  = (e <= busy_until);
    if (e == busy_until) m_mask = '0;
    if (!blocked) begin
      if (en && row < N) begin
        m_buf[row]  = v;
        m_mask[row] = 1'b1;
      end
      if (st && pre_full) begin
        for (int n = 0; n < N; n++) begin
          bi = 0;
          for (int c = 1; c < W; c++)
            if (m_buf[n][c] > m_buf[n][bi]) bi = c;
          x.ans[n] = bi[1:0];
        end
        x.cyc      = e + N*W;
        scan_k     = e;
        busy_until = e + N*W + 1;
        q.push_back(x);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, zero_row, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; enable = 1'b0; start = 1'b0;
    m_mask = '0; scan_k = -1000; busy_until = -1;
    q.delete();
  endtask

  task automatic fill_all();
    for (int i = 0; i < N; i++) step(1'b1, i, rnd_row(), 1'b0);
  endtask

  task automatic check_answers(input string nm, input int a0, input int a1, input int a2,
                               input int a3, input int a4, input int a5);
    int ex [0:N-1];
    ex = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < N; i++) check(nm, ans[i], ex[i]);
  endtask

  // Monitor: control outputs every cycle, results popped from the scoreboard on done.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (mon_on) begin
      check("busy", busy, (cyc >= scan_k && cyc <= scan_k + N*W - 1));
      check("done", done, (cyc == scan_k + N*W));
      check("rows_full", rows_full, &m_mask);
      if (done) begin
        if (q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          x = q.pop_front();
          check("done_cycle", cyc, x.cyc);
          for (int i = 0; i < N; i++) check("class", ans[i], x.ans[i]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < W; i++) begin
      dot_product[i] = '0;
      zero_row[i]    = '0;
    end
    for (int i = 0; i < N; i++) for (int j = 0; j < W; j++) m_buf[i][j] = '0;
    tbl[0] = mkrow(11488, 0, 0);
    tbl[1] = mkrow(6684, 0, 0);
    tbl[2] = mkrow(7687, 6093, 0);
    tbl[3] = mkrow(7687, 9853, 8976);
    tbl[4] = mkrow(0, 6684, 8976);
    tbl[5] = mkrow(0, 6093, 6093);

    repeat (2) @(posedge clk);
    do_reset();
    mon_on = 1'b1;
    idle(1);
    check_answers("reset_class", 0, 0, 0, 0, 0, 0);

    // start with no rows captured is ignored
    repeat (3) step(1'b0, 0, zero_row, 1'b1);
    idle(2);

    // in-order capture, tie in row 5 keeps the lower index
    for (int i = 0; i < N; i++) step(1'b1, i, tbl[i], 1'b0);
    step(1'b0, 0, zero_row, 1'b1);
    idle(N*W + 4);
    check_answers("basic_class", 0, 0, 0, 1, 2, 1);

    // out-of-order capture with a final overwrite of row 0
    step(1'b1, 5, tbl[5], 1'b0); step(1'b1, 3, tbl[3], 1'b0);
    step(1'b1, 1, tbl[1], 1'b0); step(1'b1, 0, tbl[0], 1'b0);
    step(1'b1, 2, tbl[2], 1'b0); step(1'b1, 4, tbl[4], 1'b0);
    step(1'b1, 0, mkrow(0, 0, 65535), 1'b0);
    step(1'b0, 0, zero_row, 1'b1);
    idle(N*W + 4);
    check_answers("overwrite_class", 2, 0, 0, 1, 2, 1);
    step(1'b0, 0, zero_row, 1'b1);
    idle(3);

    // illegal row index, then a write attempted mid-scan
    step(1'b1, 7, mkrow(65535, 65535, 65535), 1'b0);
    fill_all();
    step(1'b0, 0, zero_row, 1'b1);
    idle(3);
    step(1'b1, 2, mkrow(0, 0, 65535), 1'b0);
    idle(N*W + 2);

    // reset lands on scan edge E0+7
    fill_all();
    step(1'b0, 0, zero_row, 1'b1);
    idle(6);
    do_reset();
    idle(1);
    check_answers("abort_class", 0, 0, 0, 0, 0, 0);
    fill_all();
    step(1'b0, 0, zero_row, 1'b1);
    idle(N*W + 3);

    // start on the same edge as the completing capture is judged on the old mask
    for (int i = 0; i < N-1; i++) step(1'b1, i, rnd_row(), 1'b0);
    step(1'b1, N-1, rnd_row(), 1'b1);
    step(1'b0, 0, zero_row, 1'b1);
    idle(N*W + 3);

    // random traffic
    repeat (6) begin
      repeat (40)
        step($urandom_range(0, 9) < 7, $urandom_range(0, 7), rnd_row(), $urandom_range(0, 5) == 0);
      idle(N*W + 5);
    end

    check("pending_results", q.size(), 0);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
